// File: rtl/booth_seq_mult.sv
// booth_seq_mult
// Iterative radix-4 Booth multiplier. One partial-product generator is reused
// over WIDTH/2 cycles, retiring one Booth digit per cycle into a 2*WIDTH
// accumulator. Operands enter through a valid/ready handshake and the signed
// product leaves through a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept operands (IDLE and rst_n high)
//   a          multiplicand, two's complement, WIDTH bits
//   b          multiplier, two's complement, WIDTH bits
//   out_valid  prod holds a completed result
//   out_ready  consumer accepts prod
//   prod       signed product a*b, 2*WIDTH bits, registered
//   busy       high in CALC or DONE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// CALC  | retiring one Booth digit per cycle, WIDTH/2 cycles in total
// DONE  | product presented on prod with out_valid high until taken

module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);

    localparam int PW     = 2 * WIDTH;
    localparam int NSTEP  = WIDTH / 2;
    localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [PW-1:0]     a_reg;
    logic [PW-1:0]     acc;
    logic [WIDTH:0]    m_reg;
    logic [STEP_W-1:0] step;

    logic [PW-1:0]     pp;
    logic [PW-1:0]     pp_sh;
    logic [PW-1:0]     acc_next;
    logic              last_step;

    // Radix-4 Booth digit from the low three bits of the shifting multiplier.
    always_comb begin
        pp = '0;
        case (m_reg[2:0])
            3'b001, 3'b010: pp = a_reg;
            3'b011:         pp = a_reg << 1;
            3'b100:         pp = -(a_reg << 1);
            3'b101, 3'b110: pp = -a_reg;
            default:        pp = '0;
        endcase
    end

    // Each digit carries weight 4^step; wraparound modulo 2^PW is intended.
    assign pp_sh     = pp << {step, 1'b0};
    assign acc_next  = acc + pp_sh;
    assign last_step = (step == STEP_W'(NSTEP - 1));

    assign in_ready  = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            acc       <= '0;
            m_reg     <= '0;
            step      <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {{WIDTH{a[WIDTH-1]}}, a};
                        m_reg <= {b, 1'b0};
                        acc   <= '0;
                        step  <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    m_reg <= {{2{m_reg[WIDTH]}}, m_reg[WIDTH:2]};
                    step  <= step + STEP_W'(1);
                    if (last_step) begin
                        prod      <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Iterative radix-4 Booth multiplier that reuses a single partial-product generator across several cycles instead of instantiating one encoder per digit. It takes a signed WIDTH×WIDTH operand pair through a valid/ready handshake. It retires one Booth digit per cycle into a 2·WIDTH accumulator and presents the signed product through a second valid/ready handshake. It is the area-optimised sequencer for the multiplier datapath and serves any client that tolerates multi-cycle latency.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥4; product is 2·WIDTH bits
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept operands (state IDLE and rst_n high)
- a  input  WIDTH  multiplicand, two's complement
- b  input  WIDTH  multiplier, two's complement
- out_valid  output  1  prod holds a completed result
- out_ready  input  1  consumer accepts prod
- prod  output  2·WIDTH  signed product a·b, registered
- busy  output  1  high in CALC or DONE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register A ← sign-extend(a) to 2·WIDTH.
  - Register M ← {b, 1'b0} (WIDTH+1 bits).
  - Set acc ← 0, step ← 0, then go to CALC.
- CALC, each cycle:
  - Decode M[2:0]: 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - acc ← acc + (pp << 2·step), modulo 2^(2·WIDTH).
  - M ← M arithmetic-shift-right 2; step ← step+1.
  - After the cycle with step = WIDTH/2−1, go to DONE.
- DONE:
  - out_valid=1 and prod=acc, both registered.
  - On out_ready, go to IDLE; prod retains its value and out_valid drops.
- a/b are don't-care outside the accepting edge and are captured only on the handshake.
- in_valid is ignored in CALC and DONE; in_ready=0 there. Operands are not queued.
- out_ready is ignored outside DONE.
- Full signed range is exact: the product of two WIDTH-bit signed values always fits in 2·WIDTH bits, with no overflow.
- Reset (rst_n=0 at any rising edge, including mid-CALC or in DONE):
  - state ← IDLE; acc, prod, M, A, step ← 0; out_valid ← 0.
  - Any in-flight operation is discarded without producing output.
  - in_ready is forced 0 while rst_n is low.

## Timing
- Accept edge T (in_valid&in_ready): state = CALC after T.
- Accumulation edges T+1 … T+WIDTH/2. State = DONE and out_valid=1 after edge T+WIDTH/2, i.e. a latency of 4 cycles for WIDTH=8.
- Output transfer on the first edge ≥ T+WIDTH/2+1 with out_ready=1. If out_ready is already high, the transfer occurs at T+5 and in_ready=1 after it.
- Minimum initiation interval = WIDTH/2+2 cycles (6 for WIDTH=8).
- Backpressure: DONE holds prod and out_valid stable indefinitely while out_ready=0.
- Reset values after any reset edge: in_ready=1 (once rst_n high), out_valid=0, busy=0, prod=0.

## Test plan
- 7·3 with out_ready=1: accept at edge T, then out_valid=1 after T+4 with prod=0x0015. in_ready=1 after T+5.
- Corner operands, WIDTH=8: each must match the expected product and take exactly 4 CALC cycles.
  - (−128)·(−128) → 0x4000
  - (−128)·127 → 0xC080
  - 127·127 → 0x3F01
  - (−1)·(−1) → 0x0001
  - (−5)·6 → 0xFFE2
  - 0·(−77) → 0x0000
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - prod and out_valid stay stable, and in_ready stays 0.
  - Changing a/b and pulsing in_valid during this window has no effect.
  - Release out_ready: transfer occurs on the next edge.
- Reset mid-operation: assert rst_n=0 for 1 cycle at T+2 of 100·(−3).
  - out_valid never rises for that operation, and prod=0 afterwards.
  - A following 2·2 yields prod=0x0004 with normal latency.
- Back-to-back random: 10k random signed pairs with random in_valid/out_ready gaps.
  - Every result equals the sign-extended a·b reference.
  - No result is dropped or duplicated, and each input handshake maps 1:1 to an output handshake.
